// File: rtl/t_toggle_scheduler_if.sv
// Handshake bundle between requesting control logic and the toggle scheduler.
// The master side drives requests and masks; the slave side drives the T-bank pins.
interface t_toggle_scheduler_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] req_mask;
   logic [NREQ-1:0]       gnt;
   logic                  t_en;
   logic [WIDTH-1:0]      t_vec;
   logic [WIDTH-1:0]      q;
   logic                  busy;
   logic [CNT_W-1:0]      toggle_cnt;

   modport master (output req, req_mask,
                   input  gnt, t_en, t_vec, q, busy, toggle_cnt);
   modport slave  (input  req, req_mask,
                   output gnt, t_en, t_vec, q, busy, toggle_cnt);
endinterface

// File: rtl/t_toggle_scheduler.sv
// Round-robin scheduler that shares one T bank between NREQ requesters:
// one single-cycle toggle pulse per grant, then MIN_GAP idle guard cycles.
module t_toggle_scheduler #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 8,
   parameter int MIN_GAP = 1,
   parameter int CNT_W   = 16
) (
   input  logic                clk,
   input  logic                rst,
   t_toggle_scheduler_if.slave bus
);
   localparam int PW = $clog2(NREQ);
   localparam logic [3:0] GAP_INIT = 4'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

   state_t            state, state_nx;
   logic [PW-1:0]     rr_ptr, rr_nx, win;
   logic [3:0]        gap_cnt, gap_nx;
   logic [NREQ-1:0]   gnt_nx;
   logic              t_en_nx, busy_nx;
   logic [WIDTH-1:0]  t_vec_nx, q_nx;
   logic [CNT_W-1:0]  cnt_nx;

   // First set request bit at or after p, wrapping modulo NREQ.
   function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [PW-1:0]   p);
      logic [PW-1:0] w;
      logic          hit;
      int            idx;
      w   = '0;
      hit = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(p) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!hit && r[idx[PW-1:0]]) begin
            hit = 1'b1;
            w   = idx[PW-1:0];
         end
      end
      return w;
   endfunction

   assign win = rr_pick(bus.req, rr_ptr);

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         gap_cnt        <= '0;
         bus.gnt        <= '0;
         bus.t_en       <= 1'b0;
         bus.t_vec      <= '0;
         bus.q          <= '0;
         bus.busy       <= 1'b0;
         bus.toggle_cnt <= '0;
      end else begin
         state          <= state_nx;
         rr_ptr         <= rr_nx;
         gap_cnt        <= gap_nx;
         bus.gnt        <= gnt_nx;
         bus.t_en       <= t_en_nx;
         bus.t_vec      <= t_vec_nx;
         bus.q          <= q_nx;
         bus.busy       <= busy_nx;
         bus.toggle_cnt <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      rr_nx    = rr_ptr;
      gap_nx   = gap_cnt;
      gnt_nx   = '0;
      t_en_nx  = 1'b0;
      t_vec_nx = '0;
      q_nx     = bus.q;
      busy_nx  = bus.busy;
      cnt_nx   = bus.toggle_cnt;
      case (state)
         IDLE: begin
            if (|bus.req) begin
               gnt_nx   = NREQ'(1) << win;
               t_en_nx  = 1'b1;
               // Mask is captured here only; later changes do not affect this pulse.
               t_vec_nx = bus.req_mask[int'(win)*WIDTH +: WIDTH];
               busy_nx  = 1'b1;
               rr_nx    = (int'(win) == NREQ-1) ? '0 : win + 1'b1;
               state_nx = PULSE;
            end
         end
         PULSE: begin
            q_nx   = bus.q ^ bus.t_vec;
            cnt_nx = bus.toggle_cnt + 1'b1;
            if (MIN_GAP == 0) begin
               state_nx = IDLE;
               busy_nx  = 1'b0;
            end else begin
               state_nx = GAP;
               gap_nx   = GAP_INIT;
            end
         end
         GAP: begin
            if (gap_cnt == 4'd0) begin
               state_nx = IDLE;
               busy_nx  = 1'b0;
            end else begin
               gap_nx = gap_cnt - 4'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_t_toggle_scheduler.sv
// Directed bench: u_a runs with MIN_GAP=1, u_b with MIN_GAP=0 and a 3-bit counter for wrap.
module tb_t_toggle_scheduler;
   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   int   vectors = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   t_toggle_scheduler_if #(.NREQ(4), .WIDTH(8), .CNT_W(16)) ba ();
   t_toggle_scheduler_if #(.NREQ(4), .WIDTH(8), .CNT_W(3))  bb ();

   t_toggle_scheduler #(.NREQ(4), .WIDTH(8), .MIN_GAP(1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst_a), .bus(ba.slave));
   t_toggle_scheduler #(.NREQ(4), .WIDTH(8), .MIN_GAP(0), .CNT_W(3)) u_b (
      .clk(clk), .rst(rst_b), .bus(bb.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [3:0] g, input logic te,
                        input logic [7:0] qq, input logic bz, input logic [15:0] c);
      chk({tag, ".gnt"},  32'(ba.gnt), 32'(g));
      chk({tag, ".t_en"}, 32'(ba.t_en), 32'(te));
      chk({tag, ".q"},    32'(ba.q), 32'(qq));
      chk({tag, ".busy"}, 32'(ba.busy), 32'(bz));
      chk({tag, ".cnt"},  32'(ba.toggle_cnt), 32'(c));
   endtask

   logic [3:0] ord_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [7:0] ord_q [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};
   logic [3:0] alt_g [8] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100,
                             4'b0001, 4'b0100, 4'b0001, 4'b0100};
   logic [7:0] alt_q [8] = '{8'h01, 8'h05, 8'h04, 8'h00, 8'h01, 8'h05, 8'h04, 8'h00};
   logic [2:0] alt_c [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

   initial begin
      ba.req = 4'b1111;
      ba.req_mask = '0;
      bb.req = 4'b0000;
      bb.req_mask = {8'h00, 8'h04, 8'h00, 8'h01};

      // 1: reset held with all requests active
      tick(); chk_a("rst1", 4'b0000, 1'b0, 8'h00, 1'b0, 16'd0);
      tick(); chk_a("rst2", 4'b0000, 1'b0, 8'h00, 1'b0, 16'd0);
      chk("rst_b.t_en", 32'(bb.t_en), 32'd0);
      chk("rst_b.cnt", 32'(bb.toggle_cnt), 32'd0);

      // 2: single requester, two grants toggle q back to zero
      rst_a = 1'b0;
      ba.req = 4'b0001;
      ba.req_mask = {8'h00, 8'h00, 8'h00, 8'h0F};
      tick(); chk_a("g1.pulse", 4'b0001, 1'b1, 8'h00, 1'b1, 16'd0);
      chk("g1.t_vec", 32'(ba.t_vec), 32'h0F);
      ba.req = 4'b0000;
      tick(); chk_a("g1.gap", 4'b0000, 1'b0, 8'h0F, 1'b1, 16'd1);
      chk("g1.t_vec0", 32'(ba.t_vec), 32'h00);
      tick(); chk_a("g1.idle", 4'b0000, 1'b0, 8'h0F, 1'b0, 16'd1);
      ba.req = 4'b0001;
      tick(); chk_a("g2.pulse", 4'b0001, 1'b1, 8'h0F, 1'b1, 16'd1);
      ba.req = 4'b0000;
      tick(); chk_a("g2.gap", 4'b0000, 1'b0, 8'h00, 1'b1, 16'd2);
      tick(); chk_a("g2.idle", 4'b0000, 1'b0, 8'h00, 1'b0, 16'd2);

      // 3: fresh reset, all requesters held, rotation 0,1,2,3,0 every 3 cycles
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      ba.req = 4'b1111;
      ba.req_mask = {8'h08, 8'h04, 8'h02, 8'h01};
      for (int i = 0; i < 5; i++) begin
         tick(); chk_a($sformatf("rr%0d.pulse", i), ord_g[i], 1'b1,
                       (i == 0) ? 8'h00 : ord_q[i-1], 1'b1, 16'(i));
         tick(); chk_a($sformatf("rr%0d.gap", i), 4'b0000, 1'b0, ord_q[i], 1'b1, 16'(i+1));
         if (i == 4) ba.req = 4'b0000;
         tick(); chk_a($sformatf("rr%0d.idle", i), 4'b0000, 1'b0, ord_q[i], 1'b0, 16'(i+1));
      end

      // 5: reset during an all-ones pulse discards the pending update
      ba.req = 4'b0100;
      ba.req_mask = {8'h08, 8'hFF, 8'h02, 8'h01};
      tick(); chk_a("rp.pulse", 4'b0100, 1'b1, 8'h0E, 1'b1, 16'd5);
      chk("rp.t_vec", 32'(ba.t_vec), 32'hFF);
      rst_a = 1'b1;
      ba.req = 4'b0000;
      tick(); chk_a("rp.rst", 4'b0000, 1'b0, 8'h00, 1'b0, 16'd0);
      rst_a = 1'b0;
      ba.req = 4'b1111;
      tick(); chk_a("rp.first", 4'b0001, 1'b1, 8'h00, 1'b1, 16'd0);
      ba.req = 4'b0000;
      tick(); chk_a("rp.gap", 4'b0000, 1'b0, 8'h01, 1'b1, 16'd1);
      tick();

      // 6: zero mask still pulses; mask change after the grant edge is ignored
      ba.req = 4'b0010;
      ba.req_mask = {8'h08, 8'hFF, 8'h00, 8'h01};
      tick(); chk_a("z.pulse", 4'b0010, 1'b1, 8'h01, 1'b1, 16'd1);
      chk("z.t_vec", 32'(ba.t_vec), 32'h00);
      ba.req = 4'b0000;
      ba.req_mask = {8'h08, 8'hFF, 8'hFF, 8'h01};
      tick(); chk_a("z.gap", 4'b0000, 1'b0, 8'h01, 1'b1, 16'd2);
      tick(); chk_a("z.idle", 4'b0000, 1'b0, 8'h01, 1'b0, 16'd2);

      // 4: MIN_GAP=0, two requesters alternate every 2 cycles; 3-bit counter wraps
      rst_b = 1'b0;
      bb.req = 4'b0101;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("b%0d.gnt", i),  32'(bb.gnt), 32'(alt_g[i]));
         chk($sformatf("b%0d.t_en", i), 32'(bb.t_en), 32'd1);
         if (i == 7) bb.req = 4'b0000;
         tick();
         chk($sformatf("b%0d.t_en0", i), 32'(bb.t_en), 32'd0);
         chk($sformatf("b%0d.busy", i),  32'(bb.busy), 32'd0);
         chk($sformatf("b%0d.q", i),     32'(bb.q), 32'(alt_q[i]));
         chk($sformatf("b%0d.cnt", i),   32'(bb.toggle_cnt), 32'(alt_c[i]));
      end
      tick();
      chk("b.quiet", 32'(bb.t_en), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
